// File: rtl/tx_pkg.sv
// Shared types and helpers for the UART transmit frame controller.
// Frame layout: start bit, data bits LSB first, optional parity bit, stop bit.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PARITY_MODE_EVEN = 0;
    localparam int PARITY_MODE_ODD  = 1;

    function automatic int frame_width(input int data_width, input int parity_en);
        return 1 + data_width + ((parity_en != 0) ? 1 : 0) + 1;
    endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 while enabled and flags the last cycle
// of every bit period. The counter is held at zero while cleared.
module tx_baud_gen #(
    parameter int BAUD_DIV = 5208
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic baud_tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST_COUNT) ? '0 : count + 1'b1;
        end
    end

    assign baud_tick = enable && (count == LAST_COUNT);

endmodule

// File: rtl/tx_frame_ctrl.sv
// UART transmit frame controller: accepts a word over valid/ready, then serialises
// start, data (LSB first), optional parity and stop bits at the baud rate.
module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int BAUD_DIV   = 5208,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                  tx_clk,
    input  logic                  tx_arst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  baud_tick,
    output logic [3:0]            bit_select
);

    localparam int         FRAME_WIDTH = frame_width(DATA_WIDTH, PARITY_EN);
    localparam logic [3:0] LAST_DATA   = 4'(DATA_WIDTH);
    localparam logic [3:0] STOP_INDEX  = 4'(FRAME_WIDTH - 1);
    localparam logic       ODD_SELECT  = (PARITY_ODD == PARITY_MODE_ODD);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  parity_bit;
    logic                  parity_next;
    logic                  tx_out_next;
    logic [3:0]            bit_select_next;
    logic                  is_idle;

    assign is_idle  = (state == IDLE);
    assign tx_ready = is_idle;
    assign tx_done  = baud_tick && (state == STOP);

    tx_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk       (tx_clk),
        .rst       (tx_arst),
        .enable    (!is_idle),
        .clear     (is_idle),
        .baud_tick (baud_tick)
    );

    always_ff @(posedge tx_clk or posedge tx_arst) begin
        if (tx_arst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            bit_select <= '0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx_out     <= tx_out_next;
            tx_busy    <= (state_next != IDLE);
            bit_select <= bit_select_next;
        end
    end

    // tx_out is computed one cycle ahead so the line value is always a register output.
    always_comb begin
        state_next      = state;
        shift_next      = shift_reg;
        parity_next     = parity_bit;
        tx_out_next     = tx_out;
        bit_select_next = bit_select;

        case (state)
            IDLE: begin
                tx_out_next = 1'b1;
                if (tx_valid) begin
                    state_next  = START;
                    shift_next  = tx_data;
                    parity_next = (^tx_data) ^ ODD_SELECT;
                    tx_out_next = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_next  = DATA;
                    tx_out_next = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_select < LAST_DATA) begin
                        tx_out_next = shift_next[0];
                    end else if (PARITY_EN != 0) begin
                        state_next  = PARITY;
                        tx_out_next = parity_bit;
                    end else begin
                        state_next  = STOP;
                        tx_out_next = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_next  = STOP;
                    tx_out_next = 1'b1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_next  = IDLE;
                    tx_out_next = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                tx_out_next = 1'b1;
            end
        endcase

        if (baud_tick) begin
            bit_select_next = (bit_select == STOP_INDEX) ? 4'd0 : bit_select + 4'd1;
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Self-checking bench for tx_frame_ctrl: three instances (even parity, odd parity,
// no parity) driven by a vector table, directed corner cases and random frames.
module tb_tx_frame_ctrl;

    localparam int BD = 4;
    localparam int DW = 8;

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [10:0] bits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [2:0] valid;
    logic [2:0] ready;
    logic [2:0] out;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] tick;
    logic [3:0] bsel [3];

    int tests = 0;
    int fails = 0;
    int par_en  [3] = '{1, 1, 0};
    int par_odd [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    tx_frame_ctrl #(.BAUD_DIV(BD), .DATA_WIDTH(DW), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .tx_clk(clk), .tx_arst(rst), .tx_data(data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_out(out[0]), .tx_busy(busy[0]), .tx_done(done[0]),
        .baud_tick(tick[0]), .bit_select(bsel[0])
    );

    tx_frame_ctrl #(.BAUD_DIV(BD), .DATA_WIDTH(DW), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .tx_clk(clk), .tx_arst(rst), .tx_data(data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_out(out[1]), .tx_busy(busy[1]), .tx_done(done[1]),
        .baud_tick(tick[1]), .bit_select(bsel[1])
    );

    tx_frame_ctrl #(.BAUD_DIV(BD), .DATA_WIDTH(DW), .PARITY_EN(0), .PARITY_ODD(0)) dut_nopar (
        .tx_clk(clk), .tx_arst(rst), .tx_data(data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_out(out[2]), .tx_busy(busy[2]), .tx_done(done[2]),
        .baud_tick(tick[2]), .bit_select(bsel[2])
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int fw_of(input int w);
        return 1 + DW + par_en[w] + 1;
    endfunction

    // Reference frame: bit i of the result is the line level during frame position i.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input int w);
        logic [10:0] f;
        int          ones;
        int          pos;
        f    = '0;
        ones = 0;
        for (int i = 0; i < DW; i++) begin
            f[1 + i] = d[i];
            if (d[i]) ones++;
        end
        pos = DW + 1;
        if (par_en[w] != 0) begin
            if (par_odd[w] != 0) f[pos] = ((ones % 2) == 0);
            else                 f[pos] = ((ones % 2) == 1);
            pos++;
        end
        f[pos] = 1'b1;
        return f;
    endfunction

    task automatic checkIdle(input int w, input string tag);
        check($sformatf("%s dut%0d tx_out", tag, w), out[w], 1);
        check($sformatf("%s dut%0d tx_ready", tag, w), ready[w], 1);
        check($sformatf("%s dut%0d tx_busy", tag, w), busy[w], 0);
        check($sformatf("%s dut%0d bit_select", tag, w), bsel[w], 0);
        check($sformatf("%s dut%0d baud_tick", tag, w), tick[w], 0);
        check($sformatf("%s dut%0d tx_done", tag, w), done[w], 0);
    endtask

    // Presents a word at a falling edge; the following rising edge is the handshake.
    task automatic applyStimulus(input int w, input logic [7:0] d);
        @(negedge clk);
        check($sformatf("dut%0d ready before send", w), ready[w], 1);
        data     = d;
        valid[w] = 1'b1;
    endtask

    // Walks every cycle of one frame, starting with the first cycle after the handshake.
    task automatic checkOutput(input int w, input logic [10:0] exp_bits,
                               input bit noise, input bit release_valid);
        int fw;
        int total;
        int pos;
        fw    = fw_of(w);
        total = fw * BD;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            if (c == 1 && release_valid) valid[w] = 1'b0;
            if (noise) begin
                data     = 8'($urandom);
                valid[w] = 1'($urandom_range(0, 1));
            end
            pos = (c - 1) / BD;
            check($sformatf("dut%0d c%0d tx_out", w, c), out[w], int'(exp_bits[pos]));
            check($sformatf("dut%0d c%0d bit_select", w, c), bsel[w], pos);
            check($sformatf("dut%0d c%0d baud_tick", w, c), tick[w], ((c - 1) % BD) == BD - 1);
            check($sformatf("dut%0d c%0d tx_done", w, c), done[w], c == total);
            check($sformatf("dut%0d c%0d tx_busy", w, c), busy[w], 1);
            check($sformatf("dut%0d c%0d tx_ready", w, c), ready[w], 0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t       vecs [6];
        logic [7:0] rd;
        int         w;

        vecs[0] = '{0, 8'hA5, 11'h54A};
        vecs[1] = '{1, 8'h07, 11'h40E};
        vecs[2] = '{2, 8'h07, 11'h20E};
        vecs[3] = '{0, 8'h01, 11'h602};
        vecs[4] = '{1, 8'h00, 11'h600};
        vecs[5] = '{2, 8'hFF, 11'h3FE};

        rst   = 1'b1;
        data  = '0;
        valid = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) checkIdle(i, "in reset");
        rst = 1'b0;

        // Idle after reset: nothing moves
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkIdle(0, $sformatf("idle c%0d", c));
        end
        for (int i = 1; i < 3; i++) checkIdle(i, "idle end");

        // Table-driven frames across the three parity configurations
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].dut, vecs[i].data);
            checkOutput(vecs[i].dut, vecs[i].bits, 1'b0, 1'b1);
            @(negedge clk);
            checkIdle(vecs[i].dut, $sformatf("after vec%0d", i));
        end

        // Back-to-back frames with valid held high: exactly one idle cycle between them
        applyStimulus(0, 8'h55);
        @(posedge clk);
        #1 data = 8'hAA;
        checkOutput(0, 11'h4AA, 1'b0, 1'b0);
        @(negedge clk);
        checkIdle(0, "gap cycle");
        checkOutput(0, 11'h554, 1'b0, 1'b1);
        @(negedge clk);
        checkIdle(0, "after b2b");

        // Reset in the middle of data bit 3 aborts the frame immediately
        applyStimulus(0, 8'hFF);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) valid[0] = 1'b0;
        end
        check("pre-abort bit_select", bsel[0], 3);
        check("pre-abort tx_out", out[0], 1);
        check("pre-abort tx_busy", busy[0], 1);
        rst = 1'b1;
        #1;
        checkIdle(0, "abort");
        @(negedge clk);
        rst      = 1'b0;
        data     = 8'h3C;
        valid[0] = 1'b1;
        checkOutput(0, 11'h478, 1'b0, 1'b1);
        @(negedge clk);
        checkIdle(0, "after abort frame");

        // Random words with noisy inputs while busy, checked against the frame model
        for (int k = 0; k < 9; k++) begin
            w  = k % 3;
            rd = 8'($urandom);
            applyStimulus(w, rd);
            checkOutput(w, model_frame(rd, w), 1'b1, 1'b1);
            @(negedge clk);
            valid[w] = 1'b0;
            checkIdle(w, $sformatf("rand%0d gap", k));
            @(negedge clk);
            checkIdle(w, $sformatf("rand%0d settle", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_frame_ctrl.md
# tx_frame_ctrl

Transmit frame controller for the UART Tx path. It accepts a parallel byte over a valid/ready handshake and generates the baud timing from the system clock. It sequences the start, data, optional parity and stop bits onto the serial line. It exports the current bit index and a baud tick so downstream Tx stages stay aligned to the same frame position.

## Interface
Parameters:
- `BAUD_DIV`, default 5208: clock cycles per bit (50 MHz / 9600). Legal range is 2 or more.
- `DATA_WIDTH`, default 8: payload bits per frame. Legal range is 5–8.
- `PARITY_EN`, default 1: 1 appends a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `FRAME_WIDTH` (localparam) = 1 + `DATA_WIDTH` + `PARITY_EN` + 1. This is 11 at the defaults.

Ports:
- `tx_clk`, input, 1 bit: single system clock. All logic uses its rising edge.
- `tx_arst`, input, 1 bit: asynchronous, active-high reset.
- `tx_data`, input, `DATA_WIDTH` bits: payload. Sampled only on a handshake.
- `tx_valid`, input, 1 bit: upstream has a byte to send.
- `tx_ready`, output, 1 bit: block can accept a byte. High only in IDLE.
- `tx_out`, output, 1 bit: serial line. Idles at 1.
- `tx_busy`, output, 1 bit: frame in progress. Low in IDLE.
- `tx_done`, output, 1 bit: one-cycle pulse in the final cycle of the stop bit.
- `baud_tick`, output, 1 bit: one-cycle pulse in the last cycle of each bit period.
- `bit_select`, output, 4 bits: bit index of the current frame position, encoded as follows.
  - 0 = start bit.
  - 1..`DATA_WIDTH` = data bits.
  - `DATA_WIDTH`+1 = parity bit, when enabled.
  - `FRAME_WIDTH`-1 = stop bit.

## Operation
- States:
  - IDLE: waits for a handshake.
  - START: drives `tx_out`=0.
  - DATA: drives `tx_out` from the shift register, LSB first.
  - PARITY: drives the parity bit.
  - STOP: drives `tx_out`=1.
- Transitions:
  - IDLE→START on `tx_valid && tx_ready` at a clock edge. `tx_data` is captured into the shift register and parity is computed from the captured value.
  - START→DATA on `baud_tick`.
  - DATA→DATA on `baud_tick` while `bit_select` < `DATA_WIDTH`.
  - DATA→PARITY on `baud_tick` at the last data bit if `PARITY_EN`, else DATA→STOP.
  - PARITY→STOP on `baud_tick`.
  - STOP→IDLE on `baud_tick`.
- Parity value:
  - Even parity: XOR of the data bits.
  - Odd parity: the inverted XOR.
- Baud counter:
  - Width is $clog2(`BAUD_DIV`).
  - Held at 0 in IDLE and counts 0..`BAUD_DIV`-1 outside IDLE.
  - `baud_tick` = (count == `BAUD_DIV`-1) && !IDLE.
  - The counter wraps to 0 on the tick.
- `bit_select`:
  - 0 in IDLE and START.
  - Increments by 1 on each `baud_tick` and never exceeds `FRAME_WIDTH`-1.
  - Cleared to 0 on STOP→IDLE.
- Changes on `tx_data` or `tx_valid` outside IDLE are ignored. `tx_valid` may be held high continuously.
- `tx_out` comes straight from a register, with no combinational path from any input.

## Timing
- Reset values, applied immediately and asynchronously: state IDLE, `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `baud_tick`=0, `bit_select`=0, counter=0.
- Reset mid-frame aborts the frame. `tx_out` returns to 1 in the same instant, with no partial stop bit. The first handshake is accepted at the first clock edge after reset deasserts.
- Latency: the handshake edge is cycle 0. `tx_out` falls to 0 in cycle 1, which is the first START cycle.
- Bit timing: each bit lasts exactly `BAUD_DIV` cycles. A frame lasts `FRAME_WIDTH`×`BAUD_DIV` cycles from the first START cycle.
- `tx_done` coincides with the final `baud_tick` of STOP. The next cycle is IDLE with `tx_ready`=1.
- Back-to-back frames: with `tx_valid` held high, the gap between frames is exactly one IDLE cycle (`tx_out`=1).
- `tx_busy` = !IDLE, registered alongside the state.

## Structure
- Shared package `tx_pkg`:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Parity-mode constants.
  - A `FRAME_WIDTH` function of `DATA_WIDTH` and `PARITY_EN`.
- Sub-module `tx_baud_gen`:
  - Contains the baud counter and the `baud_tick` output.
  - Takes an enable input (!IDLE) and a synchronous clear.
  - Parameterised by `BAUD_DIV`.
- The FSM, shift register and parity logic stay in `tx_frame_ctrl`.

## Test plan
Unless stated otherwise, these scenarios use `BAUD_DIV`=4, `DATA_WIDTH`=8, `PARITY_EN`=1 and even parity.
1. Reset, then idle 20 cycles → `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `bit_select`=0, no `baud_tick`.
2. Send 0xA5 → `tx_out` sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,0,1. `bit_select` steps 0..10. `tx_done` pulses at cycle 44 after the handshake. Total of 11 ticks.
3. Send 0x07 with `PARITY_ODD`=1 → parity bit = 0. With `PARITY_EN`=0 → frame is 10 bits (40 cycles) and `bit_select` peaks at 9.
4. Hold `tx_valid` high with 0x55 then 0xAA → the second start bit begins exactly 2 cycles after `tx_done`, and `tx_ready` is high for exactly 1 cycle between frames.
5. Assert `tx_arst` during data bit 3 of 0xFF → `tx_out`=1 and `bit_select`=0 immediately. After release, send 0x3C → a full, correct 11-bit frame.
6. Toggle `tx_data` and `tx_valid` randomly while busy → the transmitted frame matches the byte captured at the handshake, and no extra handshake occurs.
